// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks an 8-bit register mask upward, one memory transfer per set bit.
// Optional sticky address-wrap flag is built only when LMSM_WRAP_ERR_EN is defined.
module lmsm_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_store,
  input  logic [7:0]  mask,
  input  logic [15:0] base,
  input  logic        mem_ack,
  output logic        req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [2:0]  reg_idx,
  output logic        reg_we,
  output logic [1:0]  addr_sel,
  output logic        busy,
  output logic        done,
  output logic        wrap_err
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  mask_r, mask_nxt;
  logic [15:0] addr_r, addr_nxt;
  logic        store_r, store_nxt;
  logic [2:0]  low_idx;
  logic [7:0]  mask_cleared;
  logic        ack_fire;

  // Priority pick of the lowest remaining mask bit; scanning down lets the lowest win.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_r[i]) low_idx = 3'(i);
    end
  end

  assign mask_cleared = mask_r & (mask_r - 8'd1);
  assign ack_fire     = (state == XFER) && mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mask_r  <= 8'd0;
      addr_r  <= 16'd0;
      store_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      mask_r  <= mask_nxt;
      addr_r  <= addr_nxt;
      store_r <= store_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask_r;
    addr_nxt  = addr_r;
    store_nxt = store_r;
    req       = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'd0;
    reg_idx   = 3'd0;
    reg_we    = 1'b0;
    addr_sel  = 2'b00;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          mask_nxt  = mask;
          addr_nxt  = base;
          store_nxt = is_store;
          state_nxt = (mask == 8'd0) ? DONE : XFER;
        end
      end
      XFER: begin
        req      = 1'b1;
        mem_wr   = store_r;
        mem_addr = addr_r;
        reg_idx  = low_idx;
        reg_we   = mem_ack && !store_r;
        addr_sel = 2'b10;
        busy     = 1'b1;
        if (mem_ack) begin
          mask_nxt = mask_cleared;
          addr_nxt = addr_r + 16'd1;
          if (mask_cleared == 8'd0) state_nxt = DONE;
        end
      end
      DONE: begin
        addr_sel  = 2'b10;
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef LMSM_WRAP_ERR_EN
  logic wrap_r;

  // Flag only wraps that still have transfers left to run at the wrapped address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_r <= 1'b0;
    end else if (state == IDLE && start) begin
      wrap_r <= 1'b0;
    end else if (ack_fire && addr_r == 16'hFFFF && mask_cleared != 8'd0) begin
      wrap_r <= 1'b1;
    end
  end

  assign wrap_err = wrap_r;
`else
  assign wrap_err = 1'b0;
`endif

endmodule
